// File: rtl/btn_cmd_pkg.sv
// Shared encodings for the button/UART command arbiter: operating modes and
// the command-source flag reported alongside each pulse.
package btn_cmd_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_BTN  = 2'b01,
      MODE_UART = 2'b10,
      MODE_BOTH = 2'b11
   } mode_e;

   localparam logic SRC_BTN  = 1'b0;
   localparam logic SRC_UART = 1'b1;

endpackage

// File: rtl/onehot_pri_sel.sv
// Combinational lowest-index-wins selector: grants the lowest set request bit
// and flags whether any request is present.
module onehot_pri_sel #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt,
   output logic         any_req
);

   logic found;

   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && !found) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/btn_cmd_arbiter.sv
// Merges debounced button levels and UART command strobes into one registered
// one-hot command pulse; buttons win and open a UART lockout window.
module btn_cmd_arbiter
   import btn_cmd_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int HOLD_CYCLES = 1000000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      mode,
   input  logic [N_CH-1:0] btn_level,
   input  logic [N_CH-1:0] uart_pulse,
   output logic [N_CH-1:0] cmd_pulse,
   output logic            cmd_valid,
   output logic            cmd_src,
   output logic            btn_lock,
   output logic            uart_drop
);

   localparam int W_HOLD = $clog2(HOLD_CYCLES + 1);

   mode_e             mode_q;
   logic [N_CH-1:0]   btn_prev;
   logic [N_CH-1:0]   btn_edge;
   logic [N_CH-1:0]   btn_sel;
   logic [N_CH-1:0]   uart_sel;
   logic              btn_any;
   logic              uart_any;
   logic [W_HOLD-1:0] hold_cnt;
   logic [W_HOLD-1:0] hold_cnt_nxt;
   logic [N_CH-1:0]   cmd_nxt;
   logic              src_nxt;
   logic              drop_nxt;

   assign mode_q   = mode_e'(mode);
   assign btn_edge = btn_level & ~btn_prev;

   onehot_pri_sel #(.N(N_CH)) u_btn_sel (
      .req     (btn_edge),
      .gnt     (btn_sel),
      .any_req (btn_any)
   );

   onehot_pri_sel #(.N(N_CH)) u_uart_sel (
      .req     (uart_pulse),
      .gnt     (uart_sel),
      .any_req (uart_any)
   );

   // The lockout only runs in merged mode; any other mode clears it.
   always_comb begin
      hold_cnt_nxt = '0;
      if (mode_q == MODE_BOTH) begin
         if ((|btn_level) || btn_any) begin
            hold_cnt_nxt = W_HOLD'(HOLD_CYCLES);
         end else if (hold_cnt != '0) begin
            hold_cnt_nxt = hold_cnt - W_HOLD'(1);
         end
      end
   end

   always_comb begin
      cmd_nxt  = '0;
      src_nxt  = cmd_src;
      drop_nxt = 1'b0;
      case (mode_q)
         MODE_BTN: begin
            if (btn_any) begin
               cmd_nxt = btn_sel;
               src_nxt = SRC_BTN;
            end
         end
         MODE_UART: begin
            if (uart_any) begin
               cmd_nxt = uart_sel;
               src_nxt = SRC_UART;
            end
         end
         MODE_BOTH: begin
            if (btn_any) begin
               cmd_nxt  = btn_sel;
               src_nxt  = SRC_BTN;
               drop_nxt = uart_any;
            end else if (uart_any) begin
               if (btn_lock) begin
                  drop_nxt = 1'b1;
               end else begin
                  cmd_nxt = uart_sel;
                  src_nxt = SRC_UART;
               end
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_prev  <= '0;
         hold_cnt  <= '0;
         btn_lock  <= 1'b0;
         cmd_pulse <= '0;
         cmd_valid <= 1'b0;
         cmd_src   <= SRC_BTN;
         uart_drop <= 1'b0;
      end else begin
         btn_prev  <= btn_level;
         hold_cnt  <= hold_cnt_nxt;
         btn_lock  <= (hold_cnt_nxt != '0);
         cmd_pulse <= cmd_nxt;
         cmd_valid <= |cmd_nxt;
         cmd_src   <= src_nxt;
         uart_drop <= drop_nxt;
      end
   end

endmodule
